// File: rtl/tof_measure.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tof_measure: laser trigger generator and echo time-of-flight counter.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tof_measure #(
  parameter int CNTR_WIDTH = 16,
  parameter int PULSE_LEN  = 10,
  parameter int BLANK      = 20,
  parameter int TIMEOUT    = 40000,
  parameter int PERIOD     = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  echo_in,
  output logic                  trig_out,
  output logic                  busy,
  output logic [CNTR_WIDTH-1:0] tof_count,
  output logic                  tof_valid,
  output logic                  timeout
);

  localparam int PER_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CNTR_WIDTH-1:0] C_TOF_MAX   = '1;
  localparam logic [CNTR_WIDTH-1:0] C_FIRE_LAST = CNTR_WIDTH'(PULSE_LEN - 1);
  localparam logic [CNTR_WIDTH-1:0] C_BLANK     = CNTR_WIDTH'(BLANK);
  localparam logic [CNTR_WIDTH-1:0] C_TO_LAST   = CNTR_WIDTH'(TIMEOUT - 1);
  localparam logic [PER_W-1:0]      C_PER_LAST  = PER_W'(PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRE   = 2'd1,
    S_LISTEN = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNTR_WIDTH-1:0]   tof_cnt_q, tof_cnt_d;
  logic [PER_W-1:0]        per_cnt_q, per_cnt_d;
  logic [CNTR_WIDTH-1:0]   tof_count_q, tof_count_d;
  logic                    trig_q, trig_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic                    timeout_q, timeout_d;
  logic                    echo_s1_q, echo_s2_q, echo_s3_q;
  logic                    w_rise;
  logic [CNTR_WIDTH-1:0]   w_tof_inc;

  assign w_rise    = echo_s2_q & ~echo_s3_q;
  assign w_tof_inc = (tof_cnt_q == C_TOF_MAX) ? tof_cnt_q : tof_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    tof_cnt_d   = tof_cnt_q;
    per_cnt_d   = per_cnt_q;
    tof_count_d = tof_count_q;
    trig_d      = 1'b0;
    valid_d     = 1'b0;
    timeout_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d   = S_FIRE;
          trig_d    = 1'b1;
          tof_cnt_d = '0;
          per_cnt_d = '0;
        end
      end
      S_FIRE: begin
        tof_cnt_d = w_tof_inc;
        per_cnt_d = per_cnt_q + 1'b1;
        if (tof_cnt_q == C_FIRE_LAST) begin
          state_d = S_LISTEN;
        end else begin
          trig_d = 1'b1;
        end
      end
      S_LISTEN: begin
        tof_cnt_d = w_tof_inc;
        per_cnt_d = per_cnt_q + 1'b1;
        // An echo on the very last count still wins over the timeout.
        if (w_rise && (tof_cnt_q >= C_BLANK)) begin
          tof_count_d = tof_cnt_q;
          valid_d     = 1'b1;
          state_d     = S_WAIT;
        end else if (tof_cnt_q == C_TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        per_cnt_d = per_cnt_q + 1'b1;
        if (per_cnt_q == C_PER_LAST) begin
          if (enable) begin
            state_d   = S_FIRE;
            trig_d    = 1'b1;
            tof_cnt_d = '0;
            per_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Async clear so the laser trigger is cut the instant reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tof_cnt_q   <= '0;
      per_cnt_q   <= '0;
      tof_count_q <= '0;
      trig_q      <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      echo_s1_q   <= 1'b0;
      echo_s2_q   <= 1'b0;
      echo_s3_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tof_cnt_q   <= tof_cnt_d;
      per_cnt_q   <= per_cnt_d;
      tof_count_q <= tof_count_d;
      trig_q      <= trig_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      echo_s1_q   <= echo_in;
      echo_s2_q   <= echo_s1_q;
      echo_s3_q   <= echo_s2_q;
    end
  end

  assign trig_out  = trig_q;
  assign busy      = busy_q;
  assign tof_count = tof_count_q;
  assign tof_valid = valid_q;
  assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_tof_measure.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tof_measure: shot-level reference model against tof_measure.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_tof_measure;

  localparam int CNTR_WIDTH = 16;
  localparam int PULSE_LEN  = 4;
  localparam int BLANK      = 8;
  localparam int TIMEOUT    = 100;
  localparam int PERIOD     = 200;
  localparam int N          = 4200;

  logic                  clk;
  logic                  rst_n;
  logic                  enable;
  logic                  echo_in;
  logic                  trig_out;
  logic                  busy;
  logic [CNTR_WIDTH-1:0] tof_count;
  logic                  tof_valid;
  logic                  timeout;

  tof_measure #(
    .CNTR_WIDTH (CNTR_WIDTH),
    .PULSE_LEN  (PULSE_LEN),
    .BLANK      (BLANK),
    .TIMEOUT    (TIMEOUT),
    .PERIOD     (PERIOD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .echo_in   (echo_in),
    .trig_out  (trig_out),
    .busy      (busy),
    .tof_count (tof_count),
    .tof_valid (tof_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input level held during cycle c (driven just after clock edge c).
  bit rst_v  [N];
  bit en_v   [N];
  bit echo_v [N];
  // Expected outputs during cycle c.
  bit exp_trig [N];
  bit exp_busy [N];
  bit exp_val  [N];
  bit exp_to   [N];
  int exp_cnt  [N];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Rising edge seen by the design in cycle x: level two cycles back high, three back low.
  function automatic bit rise_at(input int x, input int from);
    bit a, b;
    a = (x - 2 >= from && x - 2 < N) ? echo_v[x-2] : 1'b0;
    b = (x - 3 >= from && x - 3 < N) ? echo_v[x-3] : 1'b0;
    return a & ~b;
  endfunction

  function automatic void set_exp(input int c, input bit t, input bit b, input bit v,
                                  input bit o, input int cnt);
    exp_trig[c] = t;
    exp_busy[c] = b;
    exp_val[c]  = v;
    exp_to[c]   = o;
    exp_cnt[c]  = cnt;
  endfunction

  // Walks the run shot by shot: each shot spans PERIOD cycles from its trigger.
  task automatic build_model();
    int c, from, held, p, res, k;
    bit chain;
    c = 0; from = 0; held = 0;
    while (c < N) begin
      if (!rst_v[c]) begin
        set_exp(c, 0, 0, 0, 0, 0);
        held = 0;
        from = c + 1;
        c++;
      end else begin
        set_exp(c, 0, 0, 0, 0, held);
        if (en_v[c] && c + 1 < N) begin
          p = c + 1;
          chain = 1'b1;
          while (chain) begin
            chain = 1'b0;
            res = -1;
            for (int t = BLANK; t < TIMEOUT; t++)
              if (res < 0 && rise_at(p + t, from)) res = t;
            for (k = 0; k < PERIOD && p + k < N; k++) begin
              if (!rst_v[p+k]) break;
              set_exp(p + k, k < PULSE_LEN, 1'b1, res >= 0 && k == res + 1,
                      res < 0 && k == TIMEOUT, (res >= 0 && k > res) ? res : held);
            end
            c = p + k;
            if (k == PERIOD) begin
              if (res >= 0) held = res;
              if (en_v[p+PERIOD-1] && c < N) begin
                p = c;
                chain = 1'b1;
              end
            end
          end
        end else begin
          c++;
        end
      end
    end
  endtask

  task automatic build_stimulus();
    int mode, s, len, r;
    bit lvl;
    for (int c = 0; c < N; c++) begin
      rst_v[c] = (c >= 3); en_v[c] = 1'b0; echo_v[c] = 1'b0;
    end
    for (int c = 3; c < 1024; c++) en_v[c] = 1'b1;
    for (int c = 1210; c < 1300; c++) en_v[c] = 1'b1;
    for (int c = 34; c <= 44; c++)   echo_v[c] = 1'b1;   // shot @4: tof 30
    echo_v[206] = 1'b1; echo_v[209] = 1'b1;              // shot @204: tof 2 and 5
    for (int c = 244; c <= 250; c++) echo_v[c] = 1'b1;   // tof 40
    for (int c = 264; c <= 270; c++) echo_v[c] = 1'b1;   // tof 60, ignored
    for (int c = 590; c <= 803; c++) echo_v[c] = 1'b1;   // held high through shot @604
    for (int c = 901; c <= 920; c++) echo_v[c] = 1'b1;   // shot @804: rise lands at tof 99
    rst_v[1213] = 1'b0; rst_v[1214] = 1'b0;              // reset during FIRE of shot @1211
    for (int b = 1216; b < N; b += 40) begin
      mode = $urandom_range(0, 3);
      s = $urandom_range(0, 35);
      len = $urandom_range(1, 4);
      lvl = 1'b0;
      for (int c = b; c < b + 40 && c < N; c++) begin
        case (mode)
          0: echo_v[c] = 1'b0;
          1: echo_v[c] = 1'b1;
          2: begin
            if ($urandom_range(0, 15) == 0) lvl = ~lvl;
            echo_v[c] = lvl;
          end
          default: echo_v[c] = (c - b >= s) && (c - b < s + len);
        endcase
      end
    end
    for (int b = 1300; b < N; b += 100) begin
      lvl = ($urandom_range(0, 5) != 0);
      for (int c = b; c < b + 100 && c < N; c++) en_v[c] = lvl;
    end
    r = $urandom_range(2600, 3400);
    len = $urandom_range(1, 3);
    for (int c = r; c < r + len; c++) rst_v[c] = 1'b0;
  endtask

  // Hand-derived anchor points for the directed opening shots.
  task automatic directed_checks(input int c);
    case (c)
      3:    check_eq("tp1_trig_before", trig_out, 0);
      4:    begin check_eq("tp1_trig_rise", trig_out, 1); check_eq("tp1_busy", busy, 1); end
      7:    check_eq("tp1_trig_last", trig_out, 1);
      8:    check_eq("tp1_trig_fall", trig_out, 0);
      37:   begin check_eq("tp2_valid", tof_valid, 1); check_eq("tp2_count", tof_count, 32); end
      38:   check_eq("tp2_valid_1cyc", tof_valid, 0);
      203:  check_eq("tp2_trig_gap", trig_out, 0);
      204:  check_eq("tp2_trig_period", trig_out, 1);
      247:  begin check_eq("tp3_valid", tof_valid, 1); check_eq("tp3_count", tof_count, 42); end
      504:  begin check_eq("tp4_timeout", timeout, 1); check_eq("tp4_count_held", tof_count, 42); end
      505:  check_eq("tp4_timeout_1cyc", timeout, 0);
      704:  check_eq("tp4_held_high_timeout", timeout, 1);
      904:  begin
        check_eq("tp5_valid", tof_valid, 1);
        check_eq("tp5_count", tof_count, 99);
        check_eq("tp5_no_timeout", timeout, 0);
      end
      1203: check_eq("tp6_busy_last", busy, 1);
      1204: check_eq("tp6_busy_fall", busy, 0);
      1212: check_eq("tp7_trig_pre", trig_out, 1);
      1213: begin
        check_eq("tp7_trig_async", trig_out, 0);
        check_eq("tp7_busy_async", busy, 0);
        check_eq("tp7_count_clr", tof_count, 0);
      end
      1216: check_eq("tp7_retrigger", trig_out, 1);
      1219: check_eq("tp7_retrigger_len", trig_out, 1);
      1220: check_eq("tp7_retrigger_end", trig_out, 0);
      default: ;
    endcase
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; echo_in = 1'b0;
    build_stimulus();
    build_model();
    for (int c = 0; c < N; c++) begin
      @(posedge clk);
      #1;
      rst_n = rst_v[c]; enable = en_v[c]; echo_in = echo_v[c];
      #2;
      check_eq($sformatf("trig@%0d", c),  trig_out,  exp_trig[c]);
      check_eq($sformatf("busy@%0d", c),  busy,      exp_busy[c]);
      check_eq($sformatf("valid@%0d", c), tof_valid, exp_val[c]);
      check_eq($sformatf("tmo@%0d", c),   timeout,   exp_to[c]);
      check_eq($sformatf("count@%0d", c), tof_count, exp_cnt[c]);
      directed_checks(c);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
